// File: rtl/ita_job_scheduler_if.sv
// Request and completion handshakes between job requesters (master) and ita_job_scheduler (slave).
interface ita_job_scheduler_if #(
  parameter int NumReq = 4,
  parameter int IdW    = 2,
  parameter int CtrlW  = 1
);
  logic [NumReq-1:0]            req_valid;
  logic [NumReq-1:0]            req_ready;
  logic [NumReq-1:0][CtrlW-1:0] req_ctrl;
  logic                         done_valid;
  logic                         done_ready;
  logic [IdW-1:0]               done_id;
  logic                         done_err;
  logic [31:0]                  done_cycles;

  modport master (
    output req_valid, req_ctrl, done_ready,
    input  req_ready, done_valid, done_id, done_err, done_cycles
  );

  modport slave (
    input  req_valid, req_ctrl, done_ready,
    output req_ready, done_valid, done_id, done_err, done_cycles
  );
endinterface

// File: rtl/ita_job_scheduler.sv
// ita_job_scheduler: round-robin job intake, in-order job queue and one-at-a-time issue to ita_controller.
// Optional feature macro: ITA_SCHED_PERF_EN (per-job run-cycle counter on done_cycles).
package ita_package;
  typedef enum logic [2:0] {
    Attention       = 3'd0,
    Feedforward     = 3'd1,
    Linear          = 3'd2,
    SingleAttention = 3'd3
  } layer_e;

  typedef enum logic [3:0] {
    Idle = 4'd0, Q = 4'd1, K = 4'd2, V = 4'd3, QK = 4'd4,
    AV = 4'd5, OW = 4'd6, F1 = 4'd7, F2 = 4'd8, MatMul = 4'd9
  } step_e;

  typedef struct packed {
    logic       start;
    layer_e     layer;
    logic [7:0] eps_mult;
    logic [4:0] right_shift;
    logic [7:0] add;
    logic [3:0] tile_s;
  } ctrl_t;
endpackage

module ita_job_scheduler
  import ita_package::*;
#(
  parameter int NumReq     = 4,
  parameter int QueueDepth = 4,
  parameter int IdW        = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  ita_job_scheduler_if.slave bus,
  output ctrl_t              ita_ctrl_o,
  input  step_e              ita_step_i,
  output logic               busy_o
);
  localparam int PtrW = $clog2(QueueDepth);
  localparam int CntW = PtrW + 1;

  typedef struct packed {
    logic [IdW-1:0] id;
    ctrl_t          ctrl;
  } entry_t;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RUN, REPORT} state_e;

  state_e          state_q;
  logic [IdW-1:0]  rr_q, job_id_q, gnt_idx;
  logic            gnt_vld, push, pop, full, err_q, head_ok;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  entry_t          q_mem [QueueDepth];
  entry_t          head, push_entry;
  ctrl_t           job_ctrl_q;

  function automatic logic layer_supported(layer_e l);
    return l inside {Attention, Feedforward, Linear, SingleAttention};
  endfunction

  function automatic logic [IdW-1:0] rr_next(logic [IdW-1:0] g);
    return (int'(g) == NumReq - 1) ? '0 : g + IdW'(1);
  endfunction

  // Round-robin search starting at rr_q; the lowest offset from rr_q wins.
  always_comb begin
    int             j;
    logic [IdW-1:0] idx;
    j       = 0;
    idx     = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      j = int'(rr_q) + i;
      if (j >= NumReq) j = j - NumReq;
      idx = IdW'(j);
      if (bus.req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  // Free space uses the registered count only; a same-cycle pop is not credited.
  assign full = (cnt_q == CntW'(QueueDepth));
  assign push = gnt_vld & ~full;
  assign pop  = (state_q == ISSUE);

  always_comb begin
    bus.req_ready = '0;
    if (push) bus.req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    push_entry            = '0;
    push_entry.id         = gnt_idx;
    push_entry.ctrl       = ctrl_t'(bus.req_ctrl[gnt_idx]);
    push_entry.ctrl.start = 1'b0;
  end

  assign head    = q_mem[rd_ptr_q];
  assign head_ok = layer_supported(head.ctrl.layer);

  always_ff @(posedge clk_i) begin
    if (push) q_mem[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rr_q     <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
        rr_q     <= rr_next(gnt_idx);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      cnt_q <= cnt_q + CntW'(1);
      else if (pop && !push) cnt_q <= cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      job_ctrl_q <= '0;
      job_id_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE:   if (cnt_q != '0) state_q <= ISSUE;
        ISSUE: begin
          job_ctrl_q <= head.ctrl;
          job_id_q   <= head.id;
          err_q      <= ~head_ok;
          state_q    <= head_ok ? WAIT : REPORT;
        end
        WAIT:   if (ita_step_i != Idle) state_q <= RUN;
        RUN:    if (ita_step_i == Idle) state_q <= REPORT;
        REPORT: if (bus.done_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // In ISSUE the head drives the controller directly so start and its fields arrive together.
  always_comb begin
    ita_ctrl_o       = job_ctrl_q;
    ita_ctrl_o.start = 1'b0;
    if (state_q == ISSUE) begin
      ita_ctrl_o       = head.ctrl;
      ita_ctrl_o.start = head_ok;
    end
  end

  assign bus.done_valid = (state_q == REPORT);
  assign bus.done_id    = job_id_q;
  assign bus.done_err   = err_q;
  assign busy_o         = (state_q != IDLE) || (cnt_q != '0);

`ifdef ITA_SCHED_PERF_EN
  logic [31:0] perf_cnt_q;

  function automatic logic [31:0] sat_inc(logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  // Counter stops outside WAIT/RUN, so it is frozen for the whole REPORT phase.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                  perf_cnt_q <= '0;
    else if (state_q == ISSUE)                    perf_cnt_q <= '0;
    else if (state_q == WAIT || state_q == RUN)   perf_cnt_q <= sat_inc(perf_cnt_q);
  end

  assign bus.done_cycles = perf_cnt_q;
`else
  assign bus.done_cycles = '0;
`endif

endmodule
